// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO frequency-sweep sequencer.
package nco_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    DWELL,
    DONE
  } sweep_state_t;

  localparam logic [3:0] ADDR_START_LO = 4'd0;
  localparam logic [3:0] ADDR_START_HI = 4'd1;
  localparam logic [3:0] ADDR_STEP_LO  = 4'd2;
  localparam logic [3:0] ADDR_STEP_HI  = 4'd3;
  localparam logic [3:0] ADDR_STOP_LO  = 4'd4;
  localparam logic [3:0] ADDR_STOP_HI  = 4'd5;
  localparam logic [3:0] ADDR_DWELL_LO = 4'd6;
  localparam logic [3:0] ADDR_DWELL_HI = 4'd7;
  localparam logic [3:0] ADDR_CTRL     = 4'd8;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_LD_LO    = 2;
  localparam int unsigned CTRL_LD_HI    = 3;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SINE   = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_SAW    = 2'd3;

  localparam logic [15:0] RST_START_FCW = 16'h0008;
  localparam logic [15:0] RST_STEP      = 16'h0001;
  localparam logic [15:0] RST_STOP_FCW  = 16'hFFFF;
  localparam logic [15:0] RST_DWELL     = 16'h0001;

endpackage

// File: rtl/sweep_cfg_regs.sv
// Byte-wide write-only configuration registers for the sweep sequencer.
module sweep_cfg_regs
  import nco_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [3:0]  i_addr,
  input  logic [7:0]  i_data,
  output logic [15:0] o_start_fcw,
  output logic [15:0] o_step,
  output logic [15:0] o_stop_fcw,
  output logic [15:0] o_dwell,
  output logic        o_loop,
  output logic [1:0]  o_mode
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_start_fcw <= RST_START_FCW;
      o_step      <= RST_STEP;
      o_stop_fcw  <= RST_STOP_FCW;
      o_dwell     <= RST_DWELL;
      o_loop      <= 1'b0;
      o_mode      <= MODE_OFF;
    end else if (i_wr_en) begin
      case (i_addr)
        ADDR_START_LO: o_start_fcw[7:0]  <= i_data;
        ADDR_START_HI: o_start_fcw[15:8] <= i_data;
        ADDR_STEP_LO:  o_step[7:0]       <= i_data;
        ADDR_STEP_HI:  o_step[15:8]      <= i_data;
        ADDR_STOP_LO:  o_stop_fcw[7:0]   <= i_data;
        ADDR_STOP_HI:  o_stop_fcw[15:8]  <= i_data;
        ADDR_DWELL_LO: o_dwell[7:0]      <= i_data;
        ADDR_DWELL_HI: o_dwell[15:8]     <= i_data;
        ADDR_CTRL: begin
          o_loop <= i_data[2];
          o_mode <= i_data[1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nco_sweep_sequencer.sv
// Chirp controller: steps an FCW from start to stop, writing each into the NCO
// as low/high byte strobes and holding it for the programmed dwell time.
module nco_sweep_sequencer
  import nco_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       nco_enable,
  output logic [7:0] nco_data,
  output logic [7:0] nco_ctrl
);

  sweep_state_t        r_state, w_next_state;
  logic [15:0]         r_cur;
  logic [1:0]          r_mode;
  logic [DWELL_W-1:0]  r_cnt;
  logic                r_en;

  logic [15:0] w_start_fcw, w_step, w_stop_fcw, w_dwell, w_dwell_m1;
  logic        w_loop;
  logic [1:0]  w_mode;
  logic [16:0] w_next_fcw;
  logic        w_sweep_end;
  logic        w_cnt_zero;

  sweep_cfg_regs u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (cfg_valid && cfg_ready),
    .i_addr      (cfg_addr),
    .i_data      (cfg_data),
    .o_start_fcw (w_start_fcw),
    .o_step      (w_step),
    .o_stop_fcw  (w_stop_fcw),
    .o_dwell     (w_dwell),
    .o_loop      (w_loop),
    .o_mode      (w_mode)
  );

  // 17-bit sum so a carry out of the FCW range also ends the sweep
  assign w_next_fcw  = {1'b0, r_cur} + {1'b0, w_step};
  assign w_sweep_end = w_next_fcw[16] || (w_next_fcw[15:0] > w_stop_fcw);
  assign w_dwell_m1  = (w_dwell == 16'd0) ? 16'd0 : w_dwell - 16'd1;
  assign w_cnt_zero  = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = LOAD_LO;
      LOAD_LO: w_next_state = abort ? DONE : LOAD_HI;
      LOAD_HI: w_next_state = abort ? DONE : DWELL;
      DWELL: begin
        if (abort)
          w_next_state = DONE;
        else if (w_cnt_zero)
          w_next_state = (w_sweep_end && !w_loop) ? DONE : LOAD_LO;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_mode <= MODE_OFF;
      r_cnt  <= '0;
      r_en   <= 1'b0;
    end else begin
      r_en <= 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_cur  <= w_start_fcw;
          r_mode <= w_mode;
        end
        LOAD_HI: r_cnt <= DWELL_W'(w_dwell_m1);
        DWELL: if (!abort) begin
          if (!w_cnt_zero)       r_cnt <= r_cnt - 1'b1;
          else if (!w_sweep_end) r_cur <= w_next_fcw[15:0];
          else if (w_loop)       r_cur <= w_start_fcw;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nco_data   = '0;
    nco_ctrl   = '0;
    nco_enable = r_en;
    busy       = (r_state != IDLE);
    done       = (r_state == DONE);
    cfg_ready  = r_en && (r_state == IDLE);
    case (r_state)
      LOAD_LO: begin
        nco_data                      = r_cur[7:0];
        nco_ctrl[CTRL_LD_LO]          = 1'b1;
        nco_ctrl[CTRL_MODE_LSB +: 2]  = r_mode;
      end
      LOAD_HI: begin
        nco_data                      = r_cur[15:8];
        nco_ctrl[CTRL_LD_HI]          = 1'b1;
        nco_ctrl[CTRL_MODE_LSB +: 2]  = r_mode;
      end
      DWELL:   nco_ctrl[CTRL_MODE_LSB +: 2] = r_mode;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nco_sweep_sequencer.sv
// Directed self-checking bench for nco_sweep_sequencer.
module tb_nco_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, nco_enable;
  logic [7:0] nco_data, nco_ctrl;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  nco_sweep_sequencer #(.DWELL_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .nco_enable (nco_enable),
    .nco_data   (nco_data),
    .nco_ctrl   (nco_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] expc, expd;
  int unsigned ph;

  initial begin
    // reset state
    #2;
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", nco_enable, 0);
    chk("rst_data", nco_data, 0);
    chk("rst_ctrl", nco_ctrl, 0);
    #20 rst_n = 1'b1;
    tick();
    chk("en_after_rst", nco_enable, 1);
    chk("ready_idle", cfg_ready, 1);

    // sweep 0x0100..0x0300 step 0x0100, dwell 4, sine, no loop
    cfg_write(4'd0, 8'h00); cfg_write(4'd1, 8'h01);
    cfg_write(4'd2, 8'h00); cfg_write(4'd3, 8'h01);
    cfg_write(4'd4, 8'h00); cfg_write(4'd5, 8'h03);
    cfg_write(4'd6, 8'h04); cfg_write(4'd7, 8'h00);
    cfg_write(4'd8, 8'h01);
    pulse_start();
    for (int k = 0; k < 19; k++) begin
      if (k < 18) begin
        ph   = k % 6;
        expc = (ph == 0) ? 8'h05 : (ph == 1) ? 8'h09 : 8'h01;
        expd = (ph == 1) ? 8'(k / 6 + 1) : 8'h00;
      end else begin
        expc = 8'h00;
        expd = 8'h00;
      end
      chk($sformatf("t1_ctrl[%0d]", k), nco_ctrl, expc);
      chk($sformatf("t1_data[%0d]", k), nco_data, expd);
      chk($sformatf("t1_done[%0d]", k), done, (k == 18));
      chk($sformatf("t1_busy[%0d]", k), busy, 1);
      tick();
    end
    chk("t1_idle_done", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_ready", cfg_ready, 1);

    // start 0xFF00 step 0x0200: carry out ends sweep after one FCW
    cfg_write(4'd0, 8'h00); cfg_write(4'd1, 8'hFF);
    cfg_write(4'd2, 8'h00); cfg_write(4'd3, 8'h02);
    cfg_write(4'd4, 8'hFF); cfg_write(4'd5, 8'hFF);
    cfg_write(4'd8, 8'h02);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      expc = (k == 0) ? 8'h06 : (k == 1) ? 8'h0A : (k < 6) ? 8'h02 : 8'h00;
      expd = (k == 1) ? 8'hFF : 8'h00;
      chk($sformatf("t2_ctrl[%0d]", k), nco_ctrl, expc);
      chk($sformatf("t2_data[%0d]", k), nco_data, expd);
      chk($sformatf("t2_done[%0d]", k), done, (k == 6));
      tick();
    end

    // loop sweep 0x10,0x20,0x10,... with dwell 0 (3 cycles/step), saw mode
    cfg_write(4'd0, 8'h10); cfg_write(4'd1, 8'h00);
    cfg_write(4'd2, 8'h10); cfg_write(4'd3, 8'h00);
    cfg_write(4'd4, 8'h20); cfg_write(4'd5, 8'h00);
    cfg_write(4'd6, 8'h00); cfg_write(4'd7, 8'h00);
    cfg_write(4'd8, 8'h07);
    pulse_start();
    for (int k = 0; k < 13; k++) begin
      ph   = k % 3;
      expc = (ph == 0) ? 8'h07 : (ph == 1) ? 8'h0B : 8'h03;
      expd = (ph == 0) ? (((k / 3) % 2 == 1) ? 8'h20 : 8'h10) : 8'h00;
      chk($sformatf("t3_ctrl[%0d]", k), nco_ctrl, expc);
      chk($sformatf("t3_data[%0d]", k), nco_data, expd);
      chk($sformatf("t3_done[%0d]", k), done, 0);
      if (k == 4) begin
        chk("t3_ready_busy", cfg_ready, 0);
        cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h55;
      end else begin
        cfg_valid = 1'b0;
      end
      if (k == 12) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk("t3_abort_done", done, 1);
    chk("t3_abort_ctrl", nco_ctrl, 0);
    chk("t3_abort_data", nco_data, 0);
    tick();
    chk("t3_after_done", done, 0);
    chk("t3_after_ctrl", nco_ctrl, 0);
    chk("t3_after_busy", busy, 0);

    // no loop; abort coincides with the final dwell expiry
    cfg_write(4'd8, 8'h03);
    pulse_start();
    for (int k = 0; k < 11; k++) begin
      if (k < 6) begin
        ph   = k % 3;
        expc = (ph == 0) ? 8'h07 : (ph == 1) ? 8'h0B : 8'h03;
        expd = (ph == 0) ? ((k == 3) ? 8'h20 : 8'h10) : 8'h00;
      end else begin
        expc = 8'h00;
        expd = 8'h00;
      end
      chk($sformatf("t4_ctrl[%0d]", k), nco_ctrl, expc);
      chk($sformatf("t4_data[%0d]", k), nco_data, expd);
      chk($sformatf("t4_done[%0d]", k), done, (k == 6));
      abort = (k == 5);
      tick();
    end
    abort = 1'b0;

    // reset mid-dwell
    cfg_write(4'd6, 8'h0A);
    cfg_write(4'd8, 8'h01);
    pulse_start();
    for (int k = 0; k < 5; k++) tick();
    chk("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_ctrl", nco_ctrl, 0);
    chk("t5_data", nco_data, 0);
    chk("t5_en", nco_enable, 0);
    chk("t5_ready", cfg_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_rel_busy", busy, 0);
    chk("t5_rel_ready", cfg_ready, 1);
    chk("t5_rel_done", done, 0);

    // defaults after reset, plus a write coinciding with start
    start = 1'b1; cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h40;
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ph   = k % 3;
      expc = (ph == 0) ? 8'h04 : (ph == 1) ? 8'h08 : 8'h00;
      expd = (k == 0) ? 8'h08 : (k == 3) ? 8'h09 : 8'h00;
      chk($sformatf("t6_ctrl[%0d]", k), nco_ctrl, expc);
      chk($sformatf("t6_data[%0d]", k), nco_data, expd);
      abort = (k == 3);
      tick();
    end
    abort = 1'b0;
    chk("t6_done", done, 1);
    tick();
    chk("t6_idle", busy, 0);

    // the simultaneous write did land: next sweep starts at 0x40
    pulse_start();
    chk("t7_start_lo", nco_data, 8'h40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t7_done", done, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
